mips_cpu_muldiv: RTL and testbench

//  Iterative HI/LO multiply/divide unit for the MIPS core; replaces the single-cycle multiplier.

---
 rtl/mips_cpu_muldiv.sv | 176 +++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit.
// Runs MULT/MULTU/DIV/DIVU as WIDTH radix-2 steps plus one sign-fix cycle. It also
// holds the architectural HI/LO registers and accepts MTHI/MTLO writes.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   start            issue an operation (sampled only while idle)
//   op_div, sign     0 = multiply, 1 = divide; 1 = signed
//   a, b             rs / rt operands
//   abort            cancel the in-flight operation; no result is written
//   hi_we, lo_we     MTHI / MTLO strobes with data on wdata (idle only)
//   busy             operation in flight
//   done             one-cycle pulse when HI/LO hold a new result
//   div_by_zero      last divide had b == 0; cleared by the next accepted start
//   hi, lo           architectural HI / LO
module mips_cpu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d, work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             op_div_q, op_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic             b_zero_q, b_zero_d, done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  // Datapath: operand magnitudes, one iteration step, final sign correction.
  always_comb begin
    a_mag     = (sign && a[WIDTH-1]) ? -a : a;
    b_mag     = (sign && b[WIDTH-1]) ? -b : b;
    // Multiply: work_lo holds the remaining multiplier bits, work_hi the partial product.
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: work_hi is the partial remainder, work_lo shifts dividend out, quotient in.
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_q_q ? -{work_hi_q, work_lo_q} : {work_hi_q, work_lo_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_div_d  = op_div_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    b_zero_d  = b_zero_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !abort) begin
          op_div_d  = op_div;
          a_raw_d   = a;
          b_zero_d  = (b == '0);
          neg_q_d   = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d   = sign & a[WIDTH-1];
          opnd_d    = b_mag;
          work_hi_d = '0;
          work_lo_d = a_mag;
          cnt_d     = CntW'(WIDTH);
          dbz_d     = 1'b0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (op_div_q) begin
            // Restoring step: keep the difference only when it did not go negative.
            work_hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            work_hi_d = mul_sum[WIDTH:1];
            work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!abort) begin
          done_d = 1'b1;
          if (!op_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (b_zero_q) begin
            // Divide by zero has a fixed architectural result, not the iteration's.
            lo_d  = '1;
            hi_d  = a_raw_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_q_q ? -work_lo_q : work_lo_q;
            hi_d = neg_r_q ? -work_hi_q : work_hi_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_div_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_div_q  <= op_div_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      b_zero_q  <= b_zero_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, op_div, sign, abort, hi_we, lo_we;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests  = 0;
  int failed = 0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_div      (op_div),
    .sign        (sign),
    .a           (a),
    .b           (b),
    .abort       (abort),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op_div;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge right after the start edge. Returns at the done cycle
  // (or after the budget expires) with edges elapsed since the start edge.
  task automatic wait_done(input logic [31:0] h0, input logic [31:0] l0,
                           output int lat, output int bcnt, output logic stable);
    lat = 0; bcnt = 0; stable = 1'b1;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic issue(input logic d, input logic s, input logic [31:0] av, input logic [31:0] bv);
    op_div = d; sign = s; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int          lat, bcnt, seen;
    logic        stable;
    logic [31:0] h0, l0;

    reset = 1'b0; start = 0; op_div = 0; sign = 0; abort = 0; hi_we = 0; lo_we = 0;
    a = '0; b = '0; wdata = '0;

    vecs[0]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset dbz", {31'b0, div_by_zero}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // MTHI in idle, then both strobes in one cycle.
    hi_we = 1'b1; wdata = 32'hDEAD0000;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", hi, 32'hDEAD0000);
    check("mthi lo untouched", lo, 32'd0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi+mtlo hi", hi, 32'h0BADF00D);
    check("mthi+mtlo lo", lo, 32'h0BADF00D);

    // Table vectors.
    foreach (vecs[i]) begin
      h0 = hi; l0 = lo;
      issue(vecs[i].op_div, vecs[i].sign, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d dbz cleared on start", i), {31'b0, div_by_zero}, 32'd0);
      wait_done(h0, l0, lat, bcnt, stable);
      check($sformatf("v%0d latency", i), lat, 33);
      check($sformatf("v%0d busy cycles", i), bcnt, 33);
      check($sformatf("v%0d hi/lo stable while busy", i), {31'b0, stable}, 32'd1);
      check($sformatf("v%0d hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d dbz", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dbz});
      @(negedge clk);
      check($sformatf("v%0d done pulse width", i), {31'b0, done}, 32'd0);
      check($sformatf("v%0d dbz held", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dbz});
    end

    // Back-to-back: second start asserted in the done cycle.
    h0 = hi; l0 = lo;
    issue(1'b0, 1'b0, 32'd6, 32'd7);
    wait_done(h0, l0, lat, bcnt, stable);
    check("b2b first lo", lo, 32'd42);
    h0 = hi; l0 = lo;
    issue(1'b1, 1'b0, 32'd100, 32'd9);
    check("b2b second accepted", {31'b0, busy}, 32'd1);
    wait_done(h0, l0, lat, bcnt, stable);
    check("b2b second latency", lat, 33);
    check("b2b second lo", lo, 32'd11);
    check("b2b second hi", hi, 32'd1);

    // Ignored start and MTLO while busy, then abort at cycle 10.
    @(negedge clk);
    h0 = hi; l0 = lo;
    issue(1'b0, 1'b1, 32'd3, 32'd5);
    for (int i = 1; i < 10; i++) begin
      if (i == 5) begin
        start = 1'b1; op_div = 1'b1; a = 32'd50; b = 32'd3; lo_we = 1'b1; wdata = 32'h11111111;
      end else begin
        start = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
      if (i == 5) check("mtlo while busy ignored", lo, l0);
    end
    start = 1'b0; lo_we = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort clears busy", {31'b0, busy}, 32'd0);
    seen = 0; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      if (busy) bcnt++;
      @(negedge clk);
    end
    check("abort no done", seen, 0);
    check("abort no queued op", bcnt, 0);
    check("abort hi kept", hi, h0);
    check("abort lo kept", lo, l0);

    // Abort and start together in idle: start dropped.
    abort = 1'b1; start = 1'b1; op_div = 1'b0; a = 32'd2; b = 32'd2;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort beats start", {31'b0, busy}, 32'd0);

    // MTHI in the same cycle as start: write lands, result then overwrites it.
    hi_we = 1'b1; wdata = 32'hCAFEBABE;
    issue(1'b0, 1'b0, 32'd2, 32'd3);
    hi_we = 1'b0;
    check("start+mthi hi written", hi, 32'hCAFEBABE);
    check("start+mthi busy", {31'b0, busy}, 32'd1);
    wait_done(32'hCAFEBABE, lo, lat, bcnt, stable);
    check("start+mthi result hi", hi, 32'd0);
    check("start+mthi result lo", lo, 32'd6);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'd9, 32'd9);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midop reset busy", {31'b0, busy}, 32'd0);
    check("midop reset lo", lo, 32'd0);
    check("midop reset hi", hi, 32'd0);
    check("midop reset done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("midop reset op lost", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
